// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus bundle: instruction memory port, branch redirect from EX,
// and the valid/ready handshake toward the IF/ID register.
//   master : fetch_buffer side (drives imem_req/imem_addr and out_* payload)
//   slave  : environment side (memory, EX redirect, IF/ID consumer)
interface fetch_buffer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instruction;
  logic [15:0] out_pc_plus_1;

  modport master (
    output imem_req, imem_addr, out_valid, out_instruction, out_pc_plus_1,
    input  imem_data, redirect, redirect_addr, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instruction, out_pc_plus_1,
    output imem_data, redirect, redirect_addr, out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch stage owning the fetch PC. Issues sequential reads to
// a synchronous instruction memory, buffers {instruction, pc+1} in a FIFO,
// presents the head to IF/ID over valid/ready and flushes on EX redirects.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-low
//   bus   : fetch_buffer_if.master (imem_*, redirect*, out_*)
// Optional feature: define FETCH_BUF_BYPASS_EN to forward a returning word
// straight to the outputs when the FIFO is empty (saves one cycle latency).
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           reset,
  fetch_buffer_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [15:0] instruction;
    logic [15:0] pc_plus_1;
  } fb_entry_t;

  fb_entry_t        mem [DEPTH];
  logic [15:0]      fetch_pc;
  logic [15:0]      pending_pc;
  logic             pending;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  fb_entry_t        ret_entry;
  logic             head_valid;
  logic             issue;
  logic             bypass;
  logic             push;
  logic             pop_fifo;

  // Issue credit, output selection and push/pop decisions
  always_comb begin
    ret_entry  = '{instruction: bus.imem_data, pc_plus_1: pending_pc + 16'd1};
    head_valid = (count != '0);
    // Credit counts buffered plus in-flight words; no look-ahead to a pop,
    // so out_ready never reaches imem_req combinationally.
    issue      = reset & ~bus.redirect &
                 ((count + CNT_W'(pending)) < CNT_W'(DEPTH));
`ifdef FETCH_BUF_BYPASS_EN
    bypass     = reset & ~bus.redirect & pending & ~head_valid;
`else
    bypass     = 1'b0;
`endif
    bus.imem_req        = issue;
    bus.imem_addr       = fetch_pc;
    bus.out_valid       = reset & ~bus.redirect & (head_valid | bypass);
    bus.out_instruction = head_valid ? mem[rd_ptr].instruction : ret_entry.instruction;
    bus.out_pc_plus_1   = head_valid ? mem[rd_ptr].pc_plus_1   : ret_entry.pc_plus_1;
    // A bypassed word taken in its return cycle never enters the FIFO
    push     = reset & ~bus.redirect & pending & ~(bypass & bus.out_ready);
    pop_fifo = bus.out_valid & bus.out_ready & head_valid;
  end

  // Fetch PC, in-flight tracking and FIFO bookkeeping; redirect flushes all
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      pending    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (bus.redirect) begin
      fetch_pc   <= bus.redirect_addr;
      pending    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (issue) begin
        fetch_pc   <= fetch_pc + 16'd1;
        pending_pc <= fetch_pc;
      end
      pending <= issue;
      rd_ptr  <= rd_ptr + PTR_W'(pop_fifo);
      wr_ptr  <= wr_ptr + PTR_W'(push);
      count   <= count + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  // Entry storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ret_entry;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed vector tables, hand-written corner
// sequences and a randomized run checked by a stream-order reference model.
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fetch_buffer_if bus ();
  fetch_buffer_if bus2 ();

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  // Synchronous instruction memories: data for address seen at posedge N in N+1
  always @(posedge clk) bus.imem_data  <= word(bus.imem_addr);
  always @(posedge clk) bus2.imem_data <= word(bus2.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Second instance: free-running, captures its first three outputs
  logic [15:0] cap_pc[$];
  logic [15:0] cap_ins[$];
  always @(negedge clk) begin
    if (reset && bus2.out_valid && cap_pc.size() < 3) begin
      cap_pc.push_back(bus2.out_pc_plus_1);
      cap_ins.push_back(bus2.out_instruction);
    end
  end

  // Reference model: words leave in strict address order from the last
  // reset/redirect point; credit = requests issued minus words accepted.
  int          m_out  = 0;
  int          m_pend = 0;
  logic [15:0] m_issue_pc = 16'h0000;
  logic [15:0] m_exp_pc   = 16'h0000;
  logic        s_rst, s_redir, s_req, s_acc;
  logic [15:0] s_raddr;

  task automatic drive(input logic rst, input logic rd, input logic [15:0] ra, input logic rdy);
    reset             = rst;
    bus.redirect      = rd;
    bus.redirect_addr = ra;
    bus.out_ready     = rdy;
    @(negedge clk);
    model_check();
  endtask

  task automatic model_check();
    int          cnt;
    logic        exp_req, exp_valid;
    logic [15:0] exp_pc1;
    cnt       = m_out - m_pend;
    exp_req   = reset && !bus.redirect && (m_out < int'(DEPTH));
    exp_valid = reset && !bus.redirect && (cnt > 0 || (BYP && m_pend == 1));
    exp_pc1   = 16'(m_exp_pc + 16'd1);
    chk("m_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("m_addr", 32'(bus.imem_addr), 32'(m_issue_pc));
    chk("m_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid && bus.out_valid) begin
      chk("m_pc1", 32'(bus.out_pc_plus_1), 32'(exp_pc1));
      chk("m_ins", 32'(bus.out_instruction), 32'(word(m_exp_pc)));
    end
    if (dut.push) chk("no_overflow", 32'(dut.count == DEPTH), 32'd0);
    s_rst   = reset;
    s_redir = bus.redirect;
    s_raddr = bus.redirect_addr;
    s_req   = exp_req;
    s_acc   = exp_valid && bus.out_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!s_rst) begin
      m_out = 0; m_pend = 0; m_issue_pc = 16'h0000; m_exp_pc = 16'h0000;
    end else if (s_redir) begin
      m_out = 0; m_pend = 0; m_issue_pc = s_raddr; m_exp_pc = s_raddr;
    end else begin
      if (s_acc) begin m_out--; m_exp_pc++; end
      if (s_req) begin m_out++; m_issue_pc++; end
      m_pend = s_req ? 1 : 0;
    end
    #1;
  endtask

  task automatic cyc(input logic rst, input logic rd, input logic [15:0] ra, input logic rdy);
    drive(rst, rd, ra, rdy);
    advance();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0000);
    advance();
  endtask

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_ins;
    logic [15:0] exp_pc1;
  } vec_t;

  task automatic run_table(input string tag, input vec_t v[$]);
    foreach (v[i]) begin
      drive(1'b1, 1'b0, 16'h0, v[i].rdy);
      chk($sformatf("%s%0d_req", tag, i), 32'(bus.imem_req), 32'(v[i].exp_req));
      if (v[i].exp_req)
        chk($sformatf("%s%0d_addr", tag, i), 32'(bus.imem_addr), 32'(v[i].exp_addr));
      chk($sformatf("%s%0d_valid", tag, i), 32'(bus.out_valid), 32'(v[i].exp_valid));
      if (v[i].exp_valid) begin
        chk($sformatf("%s%0d_ins", tag, i), 32'(bus.out_instruction), 32'(v[i].exp_ins));
        chk($sformatf("%s%0d_pc1", tag, i), 32'(bus.out_pc_plus_1), 32'(v[i].exp_pc1));
      end
      advance();
    end
  endtask

  initial begin
    vec_t stream_v[$];
    vec_t stall_v[$];
    vec_t e;
    int   hit;

    reset = 1'b0;
    bus.redirect = 1'b0; bus.redirect_addr = 16'h0; bus.out_ready = 1'b0;
    bus2.redirect = 1'b0; bus2.redirect_addr = 16'h0; bus2.out_ready = 1'b1;

    // Vector tables
    for (int i = 0; i < 6; i++) begin
      e.rdy = 1'b1; e.exp_req = 1'b1; e.exp_addr = 16'(i);
      e.exp_valid = (i >= LAT);
      e.exp_ins = 16'(16'h1000 + i - LAT);
      e.exp_pc1 = 16'(i - LAT + 1);
      stream_v.push_back(e);
    end
    for (int i = 0; i < 7; i++) begin
      e.rdy = 1'b0; e.exp_req = (i < int'(DEPTH)); e.exp_addr = 16'(i);
      e.exp_valid = (i >= LAT);
      e.exp_ins = 16'h1000; e.exp_pc1 = 16'h0001;
      stall_v.push_back(e);
    end

    @(posedge clk); #1;

    // Streaming from reset with ready held high
    do_reset();
    run_table("stream", stream_v);

    // Stall fills exactly DEPTH entries, then drains in order
    do_reset();
    run_table("stall", stall_v);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'h0, 1'b1);

    // Redirect with 3 buffered, one in flight, ready and a push in same cycle
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 16'h0040, 1'b1);
    chk("redir_valid", 32'(bus.out_valid), 32'd0);
    chk("redir_req", 32'(bus.imem_req), 32'd0);
    advance();
    drive(1'b1, 1'b0, 16'h0, 1'b1);
    chk("redir_no_push", 32'(bus.out_valid), 32'd0);
    chk("redir_req_next", 32'(bus.imem_req), 32'd1);
    chk("redir_addr_next", 32'(bus.imem_addr), 32'h0040);
    advance();
    hit = 0;
    for (int k = 2; k <= 5 && hit == 0; k++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b1);
      if (bus.out_valid) begin
        hit = k;
        chk("redir_ins", 32'(bus.out_instruction), 32'h1040);
        chk("redir_pc1", 32'(bus.out_pc_plus_1), 32'h0041);
      end
      advance();
    end
    chk("redir_latency", 32'(hit), 32'(LAT + 1));

    // Reset asserted with entries buffered drops everything
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      chk("midrst_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_req", 32'(bus.imem_req), 32'd0);
      advance();
    end
    drive(1'b1, 1'b0, 16'h0, 1'b1);
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    chk("restart_addr", 32'(bus.imem_addr), 32'h0000);
    chk("restart_valid", 32'(bus.out_valid), 32'd0);
    advance();

    // Randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 19) == 0),
          16'($urandom),
          ($urandom_range(0, 9) < 7));
    end

    // Address wrap on the RESET_PC = FFFE instance
    chk("wrap_cnt", 32'(cap_pc.size()), 32'd3);
    if (cap_pc.size() == 3) begin
      chk("wrap_pc0", 32'(cap_pc[0]), 32'hFFFF);
      chk("wrap_pc1", 32'(cap_pc[1]), 32'h0000);
      chk("wrap_pc2", 32'(cap_pc[2]), 32'h0001);
      chk("wrap_ins0", 32'(cap_ins[0]), 32'(word(16'hFFFE)));
      chk("wrap_ins2", 32'(cap_ins[2]), 32'(word(16'h0000)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
